// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared constants and types for the PS/2 scan-code event path.
//   BREAK_CODE / EXT_CODE : PS/2 set-2 prefix bytes
//   prefix_state_t        : prefix FSM state encoding
//   kbd_event_t           : decoded key event {ext, brk, code}
package ps2_kbd_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } prefix_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_event_t;

  // True for either prefix byte
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == EXT_CODE) || (b == BREAK_CODE);
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: first-word-fall-through event FIFO.
// Ports:
//   clk, reset        : clock, async active-high reset
//   push, push_data   : write request and payload
//   pop_ready         : consumer ready; pop happens when valid && pop_ready
//   valid, head       : head entry present / head entry payload
//   count             : entries stored (0..FIFO_DEPTH)
//   overflow          : one-cycle pulse when a push was dropped
//   push_accept_c     : combinational, push request will be stored this cycle
module kbd_event_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1,
  parameter type         entry_t    = kbd_event_t
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop_ready,
  output logic             valid,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             push_accept_c
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  entry_t             mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               pop_c;
  logic               full_c;
  logic [CNT_W-1:0]   count_next;

  // A pop frees a slot in the same cycle, so full+push+pop is accepted
  always_comb begin
    pop_c         = valid && pop_ready;
    full_c        = (count == CNT_W'(FIFO_DEPTH));
    push_accept_c = push && (!full_c || pop_c);
    count_next    = count;
    case ({push_accept_c, pop_c})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Storage, pointers (wrap naturally at power-of-two depth) and status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_accept_c) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= count_next;
      valid    <= (count_next != '0);
      overflow <= push && full_c && !pop_c;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/scancode_event_decoder.sv
// scancode_event_decoder: turns a PS/2 set-2 byte stream into key events
// {code, ext, break} and queues them in a FWFT FIFO.
// Optional feature macro: KBD_TYPEMATIC_FILTER_EN drops auto-repeat presses
// of the most recently pushed key until that key is released.
// Ports:
//   clk, reset            : clock, async active-high reset
//   rx_valid, rx_data     : received byte strobe and byte
//   evt_valid, evt_ready  : FIFO head handshake
//   evt_code/ext/break    : head event fields
//   evt_count             : events stored
//   overflow              : one-cycle pulse when an event is dropped
module scancode_event_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow
);

  prefix_state_t state;
  prefix_state_t state_next;
  logic          emit_c;
  kbd_event_t    emit_evt_c;
  logic          suppress_c;
  logic          push_c;
  logic          push_accept_c;
  kbd_event_t    head;

  // Prefix state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Prefix decode; a non-prefix byte always completes an event
  always_comb begin
    state_next      = state;
    emit_c          = 1'b0;
    emit_evt_c      = '0;
    emit_evt_c.code = rx_data;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == EXT_CODE) begin
            state_next = EXT;
          end else if (rx_data == BREAK_CODE) begin
            state_next = BRK;
          end else begin
            emit_c = 1'b1;
          end
        end
        EXT: begin
          if (rx_data == BREAK_CODE) begin
            state_next = EXT_BRK;
          end else if (rx_data != EXT_CODE) begin
            emit_c         = 1'b1;
            emit_evt_c.ext = 1'b1;
            state_next     = IDLE;
          end
        end
        BRK: begin
          if (!is_prefix(rx_data)) begin
            emit_c         = 1'b1;
            emit_evt_c.brk = 1'b1;
            state_next     = IDLE;
          end
        end
        EXT_BRK: begin
          if (!is_prefix(rx_data)) begin
            emit_c         = 1'b1;
            emit_evt_c.ext = 1'b1;
            emit_evt_c.brk = 1'b1;
            state_next     = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef KBD_TYPEMATIC_FILTER_EN
  logic       trk_valid;
  logic       trk_ext;
  logic [7:0] trk_code;
  logic       trk_match_c;

  always_comb begin
    trk_match_c = trk_valid && (trk_ext == emit_evt_c.ext) &&
                  (trk_code == emit_evt_c.code);
    suppress_c  = emit_c && !emit_evt_c.brk && trk_match_c;
  end

  // Track the last press that actually entered the FIFO; its release clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trk_valid <= 1'b0;
      trk_ext   <= 1'b0;
      trk_code  <= '0;
    end else if (emit_c) begin
      if (!emit_evt_c.brk && push_accept_c) begin
        trk_valid <= 1'b1;
        trk_ext   <= emit_evt_c.ext;
        trk_code  <= emit_evt_c.code;
      end else if (emit_evt_c.brk && trk_match_c) begin
        trk_valid <= 1'b0;
      end
    end
  end
`else
  logic filter_unused;
  assign suppress_c    = 1'b0;
  assign filter_unused = push_accept_c;
`endif

  assign push_c = emit_c && !suppress_c;

  kbd_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W),
    .entry_t    (kbd_event_t)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push          (push_c),
    .push_data     (emit_evt_c),
    .pop_ready     (evt_ready),
    .valid         (evt_valid),
    .head          (head),
    .count         (evt_count),
    .overflow      (overflow),
    .push_accept_c (push_accept_c)
  );

  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_break = head.brk;

endmodule

// File: tb/tb_scancode_event_decoder.sv
// tb_scancode_event_decoder: directed table-driven bench for
// scancode_event_decoder (FIFO_DEPTH = 4), plus hand sequences for reset
// mid-prefix and the typematic filter (expectations follow the macro).
module tb_scancode_event_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          evt_valid;
  logic          evt_ready;
  logic [7:0]    evt_code;
  logic          evt_ext;
  logic          evt_break;
  logic [CW-1:0] evt_count;
  logic          overflow;

  scancode_event_decoder #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .evt_count (evt_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One row = inputs for the next edge and outputs expected after that edge
  typedef struct {
    logic          rv;
    logic [7:0]    data;
    logic          rdy;
    logic          v;
    logic [7:0]    code;
    logic          ext;
    logic          brk;
    logic [CW-1:0] cnt;
    logic          ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rv, input logic [7:0] data, input logic rdy,
                     input logic v, input logic [7:0] code, input logic ext,
                     input logic brk, input int cnt, input logic ovf);
    vec_t r;
    r.rv = rv; r.data = data; r.rdy = rdy;
    r.v = v; r.code = code; r.ext = ext; r.brk = brk;
    r.cnt = CW'(cnt); r.ovf = ovf;
    vecs.push_back(r);
  endtask

  logic [7:0] seq [6];
  logic [9:0] got [$];
  logic [9:0] expq [$];
  logic       ovf_seen;

  initial begin
    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset valid", 32'(evt_valid), 32'd0);
    check("reset count", 32'(evt_count), 32'd0);
    check("reset code",  32'(evt_code),  32'd0);
    check("reset ext",   32'(evt_ext),   32'd0);
    check("reset brk",   32'(evt_break), 32'd0);
    check("reset ovf",   32'(overflow),  32'd0);
    reset = 1'b0;
    @(negedge clk);

    //   rv  data   rdy  v  code   ext brk cnt ovf
    // single make with ready high: empty push is not bypassed
    add(1, 8'h1C, 1,   1, 8'h1C, 0, 0, 1, 0);
    add(0, 8'h00, 1,   0, 8'h00, 0, 0, 0, 0);
    // extended break E0 F0 75
    add(1, 8'hE0, 1,   0, 8'h00, 0, 0, 0, 0);
    add(1, 8'hF0, 1,   0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h75, 1,   1, 8'h75, 1, 1, 1, 0);
    add(0, 8'h00, 1,   0, 8'h00, 0, 0, 0, 0);
    // repeated E0 stays extended
    add(1, 8'hE0, 1,   0, 8'h00, 0, 0, 0, 0);
    add(1, 8'hE0, 1,   0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h74, 1,   1, 8'h74, 1, 0, 1, 0);
    add(0, 8'h00, 1,   0, 8'h00, 0, 0, 0, 0);
    // E0 ignored inside a break
    add(1, 8'hF0, 1,   0, 8'h00, 0, 0, 0, 0);
    add(1, 8'hE0, 1,   0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h12, 1,   1, 8'h12, 0, 1, 1, 0);
    add(0, 8'h00, 1,   0, 8'h00, 0, 0, 0, 0);
    // overflow: five makes into a depth-4 FIFO
    add(1, 8'h15, 0,   1, 8'h15, 0, 0, 1, 0);
    add(1, 8'h16, 0,   1, 8'h15, 0, 0, 2, 0);
    add(1, 8'h17, 0,   1, 8'h15, 0, 0, 3, 0);
    add(1, 8'h18, 0,   1, 8'h15, 0, 0, 4, 0);
    add(1, 8'h19, 0,   1, 8'h15, 0, 0, 4, 1);
    add(0, 8'h00, 0,   1, 8'h15, 0, 0, 4, 0);
    add(0, 8'h00, 1,   1, 8'h16, 0, 0, 3, 0);
    add(0, 8'h00, 1,   1, 8'h17, 0, 0, 2, 0);
    add(0, 8'h00, 1,   1, 8'h18, 0, 0, 1, 0);
    add(0, 8'h00, 1,   0, 8'h00, 0, 0, 0, 0);
    // full FIFO with simultaneous push and pop
    add(1, 8'h21, 0,   1, 8'h21, 0, 0, 1, 0);
    add(1, 8'h22, 0,   1, 8'h21, 0, 0, 2, 0);
    add(1, 8'h23, 0,   1, 8'h21, 0, 0, 3, 0);
    add(1, 8'h24, 0,   1, 8'h21, 0, 0, 4, 0);
    add(1, 8'h25, 1,   1, 8'h22, 0, 0, 4, 0);
    add(0, 8'h00, 1,   1, 8'h23, 0, 0, 3, 0);
    add(0, 8'h00, 1,   1, 8'h24, 0, 0, 2, 0);
    add(0, 8'h00, 1,   1, 8'h25, 0, 0, 1, 0);
    add(0, 8'h00, 1,   0, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rx_valid  = vecs[i].rv;
      rx_data   = vecs[i].data;
      evt_ready = vecs[i].rdy;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d valid", i), 32'(evt_valid), 32'(vecs[i].v));
      check($sformatf("vec%0d count", i), 32'(evt_count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d ovf", i),   32'(overflow),  32'(vecs[i].ovf));
      if (vecs[i].v) begin
        check($sformatf("vec%0d code", i), 32'(evt_code),  32'(vecs[i].code));
        check($sformatf("vec%0d ext", i),  32'(evt_ext),   32'(vecs[i].ext));
        check($sformatf("vec%0d brk", i),  32'(evt_break), 32'(vecs[i].brk));
      end
    end
    rx_valid  = 1'b0;
    evt_ready = 1'b0;

    // reset in the middle of an E0 prefix discards it
    rx_valid = 1'b1;
    rx_data  = 8'hE0;
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h1C;
    @(negedge clk);
    rx_valid = 1'b0;
    check("midreset valid", 32'(evt_valid), 32'd1);
    check("midreset code",  32'(evt_code),  32'h1C);
    check("midreset ext",   32'(evt_ext),   32'd0);
    check("midreset brk",   32'(evt_break), 32'd0);
    @(negedge clk);
    check("midreset count", 32'(evt_count), 32'd1);

    // reset with a non-empty FIFO clears everything
    reset = 1'b1;
    @(negedge clk);
    check("flush valid", 32'(evt_valid), 32'd0);
    check("flush count", 32'(evt_count), 32'd0);
    check("flush code",  32'(evt_code),  32'd0);
    reset = 1'b0;
    @(negedge clk);

    // typematic sequence 1C 1C 1C F0 1C 1C, consumer always ready
    seq[0] = 8'h1C; seq[1] = 8'h1C; seq[2] = 8'h1C;
    seq[3] = 8'hF0; seq[4] = 8'h1C; seq[5] = 8'h1C;
    evt_ready = 1'b1;
    ovf_seen  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (evt_valid) got.push_back({evt_ext, evt_break, evt_code});
      if (overflow) ovf_seen = 1'b1;
      if (i < 6) begin
        rx_valid = 1'b1;
        rx_data  = seq[i];
      end else begin
        rx_valid = 1'b0;
      end
    end
`ifdef KBD_TYPEMATIC_FILTER_EN
    expq = '{10'h01C, 10'h11C, 10'h01C};
`else
    expq = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif
    check("typematic events", 32'(got.size()), 32'(expq.size()));
    check("typematic ovf", 32'(ovf_seen), 32'd0);
    for (int k = 0; k < expq.size(); k++) begin
      if (k < got.size()) begin
        check($sformatf("typematic ev%0d", k), 32'(got[k]), 32'(expq[k]));
      end else begin
        check($sformatf("typematic ev%0d missing", k), 32'hFFFF_FFFF, 32'(expq[k]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
